// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with a whole-array clear sweep, entered on reset or a clr pulse.
// Latency: reads return on the next cycle. While busy, all port requests are dropped.
module ram_dp_clr #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_nxt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_en;
  logic                  bypass;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    mem_we        = 1'b0;
    mem_waddr     = waddr;
    mem_wdata     = wdata;
    rd_en         = 1'b0;
    busy          = 1'b0;
    case (state)
      SWEEP: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = sweep_cnt;
        mem_wdata = '0;
        if (sweep_cnt == {ADDR_WIDTH{1'b1}}) begin
          state_nxt     = IDLE;
          sweep_cnt_nxt = '0;
        end else begin
          sweep_cnt_nxt = sweep_cnt + 1'b1;
        end
      end
      IDLE: begin
        // A clear request drops a coincident write but still serves a read.
        rd_en = re;
        if (clr) begin
          state_nxt = SWEEP;
        end else if (we) begin
          mem_we = 1'b1;
        end
      end
      default: state_nxt = SWEEP;
    endcase
  end

  assign bypass = (RDW_MODE == 1) && mem_we && (mem_waddr == raddr);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= bypass ? wdata : mem[raddr];
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Directed bench: two 16x8 instances (old-data and bypass read-during-write) sharing
// stimulus, plus a 64x32 instance for the wide configuration.
module tb_ram_dp_clr;

  logic        clk;
  logic        rst_n;
  logic        we, re, clr;
  logic [3:0]  waddr, raddr;
  logic [7:0]  wdata;
  logic [7:0]  rdata0, rdata1;
  logic        rvalid0, rvalid1, busy0, busy1;

  logic        we2, re2, clr2;
  logic [5:0]  waddr2, raddr2;
  logic [31:0] wdata2, rdata2;
  logic        rvalid2, busy2;

  int checks = 0;
  int errors = 0;

  ram_dp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr(raddr), .clr(clr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
  );

  ram_dp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
    .raddr(raddr), .clr(clr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  ram_dp_clr #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RDW_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .we(we2), .waddr(waddr2), .wdata(wdata2), .re(re2),
    .raddr(raddr2), .clr(clr2), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int b0 = 0;
    int b1 = 0;
    int b2 = 0;
    checks++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_state busy=%b rvalid=%b rdata=%h required 1 0 00", busy0, rvalid0, rdata0);
    end
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick;
      if (b0 == 0 && busy0 === 1'b0) b0 = i;
      if (b1 == 0 && busy1 === 1'b0) b1 = i;
      if (b2 == 0 && busy2 === 1'b0) b2 = i;
    end
    checks++;
    if (b0 != 16 || b1 != 16) begin
      errors++;
      $display("FAIL reset_sweep_len got %0d/%0d cycles required 16", b0, b1);
    end
    checks++;
    if (b2 != 64) begin
      errors++;
      $display("FAIL reset_sweep_len_wide got %0d cycles required 64", b2);
    end
    for (int a = 0; a < 16; a++) begin
      re = 1'b1;
      raddr = 4'(a);
      tick;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
        errors++;
        $display("FAIL reset_zero addr %0d rvalid=%b rdata=%h/%h required 1 00", a, rvalid0, rdata0, rdata1);
      end
    end
    re = 1'b0;
    tick;
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rvalid_drop rvalid=%b required 0", rvalid0);
    end
  endtask

  task automatic test_write_read;
    we = 1'b1; waddr = 4'd3; wdata = 8'hA5;
    tick;
    we = 1'b0; re = 1'b1; raddr = 4'd3;
    tick;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin
      errors++;
      $display("FAIL wr_rd_addr3 rvalid=%b rdata=%h required 1 a5", rvalid0, rdata0);
    end
    raddr = 4'd4;
    tick;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL wr_rd_addr4 rvalid=%b rdata=%h required 1 00", rvalid0, rdata0);
    end
    re = 1'b0;
    tick;
    checks++;
    if (rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL rd_hold rvalid=%b rdata=%h required 0 00", rvalid0, rdata0);
    end
  endtask

  task automatic test_rdw;
    we = 1'b1; waddr = 4'd7; wdata = 8'h11;
    tick;
    wdata = 8'h22; re = 1'b1; raddr = 4'd7;
    tick;
    checks++;
    if (rdata0 !== 8'h11 || rdata1 !== 8'h22 || rvalid0 !== 1'b1 || rvalid1 !== 1'b1) begin
      errors++;
      $display("FAIL rdw_same rdata mode0=%h mode1=%h required 11 22", rdata0, rdata1);
    end
    we = 1'b0;
    tick;
    checks++;
    if (rdata0 !== 8'h22 || rdata1 !== 8'h22) begin
      errors++;
      $display("FAIL rdw_after rdata mode0=%h mode1=%h required 22 22", rdata0, rdata1);
    end
    we = 1'b1; waddr = 4'd9; wdata = 8'h99; raddr = 4'd3;
    tick;
    checks++;
    if (rdata0 !== 8'hA5 || rdata1 !== 8'hA5) begin
      errors++;
      $display("FAIL rdw_diff rdata=%h/%h required a5", rdata0, rdata1);
    end
    we = 1'b0; raddr = 4'd9;
    tick;
    checks++;
    if (rdata0 !== 8'h99 || rdata1 !== 8'h99) begin
      errors++;
      $display("FAIL rdw_diff_wr rdata=%h/%h required 99", rdata0, rdata1);
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i);
      wdata = 8'h40 + 8'(i);
      tick;
    end
    we = 1'b0;
    re = 1'b1;
    for (int i = 0; i < 16; i++) begin
      raddr = 4'(15 - i);
      exp = 8'h4F - 8'(i);
      tick;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== exp) begin
        errors++;
        $display("FAIL b2b addr %0d rvalid=%b rdata=%h required 1 %h", 15 - i, rvalid0, rdata0, exp);
      end
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_clr;
    int busy_cnt = 1;
    int rv_seen = 0;
    we = 1'b1; wdata = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      waddr = 4'(i);
      tick;
    end
    clr = 1'b1; waddr = 4'd0; wdata = 8'h33;
    tick;
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_busy_start busy=%b required 1", busy0);
    end
    clr = 1'b0; waddr = 4'd5; wdata = 8'h77; re = 1'b1; raddr = 4'd5;
    for (int i = 1; i <= 20; i++) begin
      clr = (i == 5);
      tick;
      if (rvalid0 !== 1'b0) rv_seen++;
      if (busy0 === 1'b1) begin
        busy_cnt++;
      end else begin
        break;
      end
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL clr_busy_len got %0d cycles required 16", busy_cnt);
    end
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL clr_read_ignored rvalid seen %0d times required 0", rv_seen);
    end
    re = 1'b1;
    for (int a = 0; a < 16; a++) begin
      raddr = 4'(a);
      tick;
      checks++;
      if (rvalid0 !== 1'b1 || rdata0 !== 8'h00) begin
        errors++;
        $display("FAIL clr_zero addr %0d rvalid=%b rdata=%h required 1 00", a, rvalid0, rdata0);
      end
    end
    re = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    int b0 = 0;
    int b2 = 0;
    we = 1'b1; waddr = 4'd2; wdata = 8'h5A;
    tick;
    we = 1'b0; clr = 1'b1; re = 1'b1; raddr = 4'd2;
    tick;
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL clr_with_read rvalid=%b rdata=%h busy=%b required 1 5a 1", rvalid0, rdata0, busy0);
    end
    clr = 1'b0; re = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    checks++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h5A) begin
      errors++;
      $display("FAIL mid_sweep busy=%b rvalid=%b rdata=%h required 1 0 5a", busy0, rvalid0, rdata0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_async busy=%b rvalid=%b rdata=%h required 1 0 00", busy0, rvalid0, rdata0);
    end
    tick;
    tick;
    #3;
    rst_n = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      tick;
      if (b0 == 0 && busy0 === 1'b0) b0 = i;
      if (b2 == 0 && busy2 === 1'b0) b2 = i;
    end
    checks++;
    if (b0 != 16 || b2 != 64) begin
      errors++;
      $display("FAIL mid_reset_sweep_len got %0d/%0d cycles required 16/64", b0, b2);
    end
  endtask

  task automatic test_wide;
    we2 = 1'b1; waddr2 = 6'd63; wdata2 = 32'hDEADBEEF;
    tick;
    we2 = 1'b0; re2 = 1'b1; raddr2 = 6'd63;
    tick;
    checks++;
    if (rvalid2 !== 1'b1 || rdata2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wide_rd63 rvalid=%b rdata=%h required 1 deadbeef", rvalid2, rdata2);
    end
    raddr2 = 6'd62;
    tick;
    checks++;
    if (rvalid2 !== 1'b1 || rdata2 !== 32'h0) begin
      errors++;
      $display("FAIL wide_rd62 rvalid=%b rdata=%h required 1 00000000", rvalid2, rdata2);
    end
    re2 = 1'b0;
    tick;
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b0; re = 1'b0; clr = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    we2 = 1'b0; re2 = 1'b0; clr2 = 1'b0; waddr2 = '0; raddr2 = '0; wdata2 = '0;
    #1;
    test_reset;
    test_write_read;
    test_rdw;
    test_back_to_back;
    test_clr;
    test_reset_mid;
    test_wide;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 4, address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, word width.
REQ-003 SHALL provide parameter RDW_MODE, default 0, read-during-write to same address: 0 = old data, 1 = new data (bypass).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 we  input  1  write enable.
REQ-008 waddr  input  ADDR_WIDTH  write address.
REQ-009 wdata  input  DATA_WIDTH  write data.
REQ-010 re  input  1  read enable.
REQ-011 raddr  input  ADDR_WIDTH  read address, independent of waddr.
REQ-012 clr  input  1  single-cycle request to zero the whole memory.
REQ-013 rdata  output  DATA_WIDTH  registered read data.
REQ-014 rvalid  output  1  one-cycle strobe, rdata updated this cycle.
REQ-015 busy  output  1  clear sweep in progress; ports ignored.

Function
REQ-016 SHALL hold DEPTH x DATA_WIDTH storage; simple dual-port, one write and one read per cycle.
REQ-017 SHALL implement FSM states SWEEP and IDLE; busy = 1 exactly when state is SWEEP.
REQ-018 SWEEP: writes 0 to address sweep_cnt each edge, sweep_cnt increments from 0; on write of DEPTH-1 -> IDLE, sweep_cnt back to 0 (no wrap past DEPTH-1).
REQ-019 IDLE -> SWEEP when clr = 1 at an edge; sweep writes occur on the following DEPTH edges; busy high for exactly DEPTH cycles.
REQ-020 In IDLE with we = 1 and clr = 0, SHALL write wdata to waddr at the edge.
REQ-021 In IDLE with re = 1, SHALL load rdata from raddr at the edge and assert rvalid for that next cycle only; read latency 1 cycle.
REQ-022 With re = 0 or in SWEEP, rdata SHALL hold its last value and rvalid SHALL be 0.
REQ-023 we, re, clr SHALL be ignored while busy = 1 (no write, no read, no sweep restart).
REQ-024 clr and we in same IDLE cycle: clr wins, write dropped; clr and re in same cycle: read performed (rvalid next cycle), sweep starts.
REQ-025 re and we same cycle, raddr = waddr: RDW_MODE 0 -> rdata = prior content; RDW_MODE 1 -> rdata = wdata.
REQ-026 re and we same cycle, different addresses: both SHALL complete independently.
REQ-027 Back-to-back reads each cycle SHALL give rvalid continuously high with one new word per cycle.

Reset
REQ-028 rst_n = 0 SHALL immediately force state SWEEP, sweep_cnt 0, busy 1, rvalid 0, rdata 0, regardless of clk.
REQ-029 After rst_n rises, SHALL sweep DEPTH words on the next DEPTH edges, then busy = 0; memory fully zero.
REQ-030 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0; partial contents not preserved.

Verification
REQ-031 Reset release, defaults -> busy high exactly 16 cycles, then 0; reads of all 16 addresses return 0x00 with rvalid one cycle after each re.
REQ-032 Write 0xA5 to addr 3, then re raddr 3 -> rdata 0xA5, rvalid high 1 cycle; raddr 4 -> 0x00.
REQ-033 Addr 7 holds 0x11, same cycle we wdata 0x22 addr 7 + re raddr 7 -> RDW_MODE 0 rdata 0x11, RDW_MODE 1 rdata 0x22; later read 0x22 both modes.
REQ-034 Fill all addresses with 0xFF, pulse clr with we=1 (addr 0, 0x33) -> busy 16 cycles, write dropped, we/re during busy ignored (rvalid 0), all reads 0x00 afterward.
REQ-035 Assert rst_n = 0 at sweep count 8, hold 2 cycles, release -> busy immediately 1, rdata/rvalid 0, full 16-cycle sweep from address 0.
REQ-036 ADDR_WIDTH 6, DATA_WIDTH 32: write address 63 0xDEADBEEF, read back correct; sweep length 64 cycles.
